// File: rtl/div_iter_if.sv
// div_iter_if: start/busy handshake and result bus of the iterative divider
// master: drives start, rs1, rs2, div_op, kill; slave: drives busy, valid, rd
interface div_iter_if #(parameter int XLEN = 32);
  logic            start;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [1:0]      div_op;
  logic            kill;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] rd;
  modport master (output start, rs1, rs2, div_op, kill, input busy, valid, rd);
  modport slave (input start, rs1, rs2, div_op, kill, output busy, valid, rd);
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// clk, rst_n (async, active-low); bus.slave: start/rs1/rs2/div_op/kill in,
// busy/valid/rd out. 33-cycle latency, 1-cycle fast path for /0 and overflow.
module div_iter #(parameter int XLEN = 32) (
  input logic       clk,
  input logic       rst_n,
  div_iter_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic [1:0]      state_q, state_d, op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, rd_q, rd_d;
  logic            sgn, s1, s2, is_rem, zero, ovf, fast, ge, last;
  logic [XLEN-1:0] a1, a2, fast_res, quo_n, rem_n, res_sel, res_fix;
  logic [XLEN:0]   rem_sh, diff;
  assign sgn      = ~bus.div_op[0];
  assign is_rem   = bus.div_op[1];
  assign s1       = sgn & bus.rs1[XLEN-1];
  assign s2       = sgn & bus.rs2[XLEN-1];
  assign a1       = s1 ? -bus.rs1 : bus.rs1;
  assign a2       = s2 ? -bus.rs2 : bus.rs2;
  assign zero     = bus.rs2 == '0;
  assign ovf      = sgn && bus.rs1 == MIN && &bus.rs2;
  assign fast     = zero || ovf;
  // divide-by-zero returns the raw dividend as remainder, without sign fix
  assign fast_res = zero ? (is_rem ? bus.rs1 : {XLEN{1'b1}}) : (is_rem ? '0 : MIN);
  // one restoring step; the XLEN+1 bit partial remainder lives only here,
  // since the stored remainder is always below the divisor
  assign rem_sh   = {rem_q, dvd_q[XLEN-1]};
  assign diff     = rem_sh - {1'b0, dvs_q};
  assign ge       = ~diff[XLEN];
  assign rem_n    = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_n    = {dvd_q[XLEN-2:0], ge};
  assign last     = cnt_q == CW'(XLEN-1);
  assign res_sel  = op_q[1] ? rem_n : quo_n;
  assign res_fix  = neg_q ? -res_sel : res_sel;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    rd_d    = rd_q;
    if (bus.kill) state_d = IDLE;
    else if (state_q == IDLE && bus.start) begin
      op_d    = bus.div_op;
      neg_d   = is_rem ? s1 : s1 ^ s2;
      dvd_d   = a1;
      dvs_d   = a2;
      rem_d   = '0;
      cnt_d   = '0;
      state_d = fast ? DONE : CALC;
      rd_d    = fast ? fast_res : rd_q;
    end else if (state_q == CALC) begin
      dvd_d   = quo_n;
      rem_d   = rem_n;
      cnt_d   = cnt_q + CW'(1);
      state_d = last ? DONE : CALC;
      rd_d    = last ? res_fix : rd_q;
    end else if (state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      rd_q    <= rd_d;
    end
  end
  assign bus.busy  = state_q != IDLE;
  assign bus.valid = state_q == DONE;
  assign bus.rd    = rd_q;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter against an arithmetic model
module tb_div_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  div_iter_if #(.XLEN(32)) bus ();
  div_iter #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? a % b : a / b;
  endfunction
  function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  logic        m_calc, m_valid;
  int          m_pend;
  logic [31:0] m_res, m_rd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_calc <= 0; m_valid <= 0; m_pend <= 0; m_rd <= 0; m_res <= 0;
    end else if (bus.kill) begin
      m_calc <= 0; m_valid <= 0;
    end else if (m_valid) m_valid <= 0;
    else if (m_calc) begin
      if (m_pend == 1) begin
        m_calc <= 0; m_valid <= 1; m_rd <= m_res;
      end
      m_pend <= m_pend - 1;
    end else if (bus.start) begin
      if (is_fast(bus.div_op, bus.rs1, bus.rs2)) begin
        m_valid <= 1; m_rd <= ref_res(bus.div_op, bus.rs1, bus.rs2);
      end else begin
        m_calc <= 1; m_pend <= 32; m_res <= ref_res(bus.div_op, bus.rs1, bus.rs2);
      end
    end
  end
  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_calc | m_valid));
    check("valid", 32'(bus.valid), 32'(m_valid));
    check("rd", bus.rd, m_rd);
  end
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    bus.div_op = op; bus.rs1 = a; bus.rs2 = b; bus.start = 1;
    do begin
      @(negedge clk);
      bus.start = 0;
      lat++;
    end while (!bus.valid && lat < 40);
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", bus.rd, exp);
    @(negedge clk);
  endtask
  initial begin
    int nv;
    bus.start = 0; bus.kill = 0; bus.rs1 = 0; bus.rs2 = 0; bus.div_op = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_rd", bus.rd, 0);
    rst_n = 1;
    @(negedge clk);
    run(DIV, 7, 2, 3, 33);
    run(REM, 7, 2, 1, 33);
    run(DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33);
    run(REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 33);
    run(DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run(DIVU, 32'hFFFF_FFFF, 2, 32'h7FFF_FFFF, 33);
    run(REMU, 32'hFFFF_FFFF, 2, 1, 33);
    run(REMU, 100, 7, 2, 33);
    run(DIV, 5, 0, 32'hFFFF_FFFF, 1);
    run(REM, 5, 0, 5, 1);
    run(REM, 32'hFFFF_FFF9, 0, 32'hFFFF_FFF9, 1);
    run(DIVU, 32'h8000_0000, 0, 32'hFFFF_FFFF, 1);
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33);
    // a second start mid-operation is ignored
    bus.div_op = DIV; bus.rs1 = 7; bus.rs2 = 2; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (9) @(negedge clk);
    bus.div_op = DIVU; bus.rs1 = 32'hFFFF_FFFF; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.valid) begin
        nv++;
        check("ignored_start_rd", bus.rd, 3);
      end
      @(negedge clk);
    end
    check("ignored_start_count", 32'(nv), 1);
    // kill in DONE: valid still shows that cycle, then IDLE
    bus.div_op = DIV; bus.rs1 = 5; bus.rs2 = 0; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    check("kill_done_valid", 32'(bus.valid), 1);
    bus.kill = 1;
    @(negedge clk);
    bus.kill = 0;
    check("kill_done_busy", 32'(bus.busy), 0);
    // kill with start in IDLE drops the request
    bus.div_op = DIV; bus.rs1 = 9; bus.rs2 = 3; bus.start = 1; bus.kill = 1;
    @(negedge clk);
    bus.start = 0; bus.kill = 0;
    check("kill_start_busy", 32'(bus.busy), 0);
    // kill at cycle 15
    bus.div_op = DIV; bus.rs1 = 100; bus.rs2 = 7; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (14) @(negedge clk);
    check("pre_kill_busy", 32'(bus.busy), 1);
    bus.kill = 1;
    @(negedge clk);
    bus.kill = 0;
    check("kill_busy", 32'(bus.busy), 0);
    check("kill_rd", bus.rd, 32'hFFFF_FFFF);
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.valid) nv++;
      @(negedge clk);
    end
    check("kill_no_valid", 32'(nv), 0);
    // asynchronous reset at cycle 20
    bus.div_op = DIV; bus.rs1 = 100; bus.rs2 = 7; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (19) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_valid", 32'(bus.valid), 0);
    check("arst_rd", bus.rd, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(DIV, 100, 7, 14, 33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions; the inverse companion to the pipelined multiplier in the execute path. It accepts one operation through a start/busy handshake and produces the quotient or remainder after a fixed 33-cycle latency. Divide-by-zero and signed-overflow cases take a one-cycle fast path. The pipeline stalls on `busy` and captures `rd` when `valid` pulses.

## Interface
- `XLEN`, 32, operand/result width; power of two, ≥ 8
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only when `busy`=0
- `rs1`  in  XLEN  dividend; sampled with `start`
- `rs2`  in  XLEN  divisor; sampled with `start`
- `div_op`  in  2  funct3[1:0]: 00=DIV, 01=DIVU, 10=REM, 11=REMU
- `kill`  in  1  synchronous flush; aborts any operation in progress
- `busy`  out  1  high in CALC and DONE
- `valid`  out  1  one-cycle pulse; `rd` is valid in the same cycle
- `rd`  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)

## Operation
- States: IDLE, CALC, DONE. Reset puts the block in IDLE with `busy`=0, `valid`=0, `rd`=0, counter=0, and internal registers cleared.
- IDLE with `start`=1 and `kill`=0 latches `div_op`, the result sign flags and the operand magnitudes.
  - Signed ops: magnitude = two's-complement absolute value. Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
  - Unsigned ops: raw operands, sign flags 0.
- Fast path, IDLE→DONE directly:
  - `rs2`=0: quotient = all ones; remainder = `rs1` unmodified (no sign fix).
  - DIV/REM with `rs1`=0x8000_0000 and `rs2`=0xFFFF_FFFF: quotient = 0x8000_0000, remainder = 0.
- Normal path, IDLE→CALC with counter=0.
  - Each CALC cycle performs one restoring step. The partial remainder (XLEN+1 bits) shifts left and takes in the dividend MSB. Subtract the divisor; if the result is non-negative, keep it and shift 1 into the quotient, otherwise shift 0.
  - Counter increments each step. After step XLEN (counter = XLEN−1 at the edge), go CALC→DONE.
- DONE: apply the sign fix (negate if the flag is set) and select quotient/remainder per `div_op`. `rd` is registered on entry to DONE. `valid`=1 for exactly one cycle, then DONE→IDLE.
- `rd` holds the last result until the next DONE. It is not cleared on return to IDLE.
- `start` while `busy`=1 is ignored. No queueing.
- `kill`=1 in any state forces IDLE on the next edge, and `valid` stays 0.
  - `kill` in DONE: the `valid` pulse of that cycle still shows combinationally. The pipeline must gate it with its own kill.
  - `kill` and `start` together in IDLE: `kill` wins and the request is dropped.
- Back-to-back: `start` sampled in the cycle right after DONE (IDLE) is accepted.

## Timing
- Normal op: `start` sampled at edge E0. Edges E1..E32 do the iterations. DONE spans E32→E33, so `valid` is high in cycle 33 after acceptance. `busy` is high from E0 to E33.
- Fast path: `start` at E0, DONE/`valid` in the cycle E0→E1. Latency is 1.
- Asynchronous `rst_n` assertion mid-operation immediately drops `busy` and `valid` and clears `rd`. After deassertion the block waits in IDLE for a new `start`.
- `busy` and `valid` are decoded directly from the state register (glitch-free, no input feedthrough).

## Test plan
- DIV 7/2 → `rd`=3, `valid` exactly 33 cycles after `start`. REM 7/2 → 1.
- DIV 0xFFFF_FFF9 (−7)/2 → 0xFFFF_FFFD. REM → 0xFFFF_FFFF. DIVU 0xFFFF_FFFF/2 → 0x7FFF_FFFF. REMU → 1.
- Divide by zero: DIV 5/0 → 0xFFFF_FFFF, REM 5/0 → 5, DIVU 0x8000_0000/0 → 0xFFFF_FFFF. Each produces `valid` one cycle after `start`.
- Overflow: DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000 and REM → 0, both in 1 cycle. DIVU on the same operands → 0 via the normal 33-cycle path.
- Handshake:
  - A second `start` at cycle 10 of an op is ignored; only the first result appears.
  - `kill` at cycle 15 → `busy` drops next edge, no `valid`, `rd` keeps the prior value.
  - A new `start` in the cycle after `valid` → result 33 cycles later.
- Async reset: drop `rst_n` at cycle 20 of DIV 100/7 → `busy`=0, `valid`=0, `rd`=0 immediately. After release, DIV 100/7 → 14 with normal latency.
